cmp_nibble_driver: RTL and testbench



---
 rtl/cmp_drv_pkg.sv | 33 +++
 rtl/cmp_nibble_driver_timer.sv | 28 ++
 rtl/cmp_nibble_driver.sv | 148 ++++++++++++++
 tb/tb_cmp_nibble_driver.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_drv_pkg.sv
// Shared types and constants for the comparator nibble driver: FSM states,
// nibble indices, timer width and the nibble select helper.
package cmp_drv_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  localparam logic [1:0] NIB_A_LO = 2'd0;
  localparam logic [1:0] NIB_A_HI = 2'd1;
  localparam logic [1:0] NIB_B_LO = 2'd2;
  localparam logic [1:0] NIB_B_HI = 2'd3;

  // Fixed load order: A low, A high, B low, B high.
  function automatic logic [3:0] nibble_sel(input logic [1:0] idx,
                                            input logic [7:0] op_a,
                                            input logic [7:0] op_b);
    case (idx)
      NIB_A_LO: return op_a[3:0];
      NIB_A_HI: return op_a[7:4];
      NIB_B_LO: return op_b[3:0];
      default:  return op_b[7:4];
    endcase
  endfunction

endpackage

// File: rtl/cmp_nibble_driver_timer.sv
// phase_timer: loadable down-counter that flags expiry when it reaches zero.
// Loading N-1 on state entry keeps the owning state active for exactly N cycles.
module phase_timer
  import cmp_drv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             expire
);

  logic [TMR_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expire = (count == '0);

endmodule

// File: rtl/cmp_nibble_driver.sv
// Host-side sequencer that loads two operands into the eight_bit_comp as four
// strobed nibbles and captures its LEDs. Optional: CMP_DRV_CHECK_EN adds `mismatch`.
module cmp_nibble_driver
  import cmp_drv_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [3:0] y,
  output logic       pb1,
  output logic       pb2,
  output logic       pb3,
  output logic       pb4,
  input  logic       l0,
  input  logic       l1,
  input  logic       l2,
  output logic       busy,
  output logic       done,
`ifdef CMP_DRV_CHECK_EN
  output logic       mismatch,
`endif
  output logic [2:0] result
);

  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

  state_t           state, state_next;
  logic [1:0]       nib, nib_next;
  logic [7:0]       op_a, op_b, op_a_next, op_b_next;
  logic             tmr_load, expire;
  logic [TMR_W-1:0] tmr_value;
  logic [3:0]       pb, pb_next, y_next;

  phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (expire)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    nib_next   = nib;
    op_a_next  = op_a;
    op_b_next  = op_b;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_SETUP;
        nib_next   = NIB_A_LO;
        op_a_next  = a;
        op_b_next  = b;
        tmr_load   = 1'b1;
        tmr_value  = SETUP_LD;
      end
      S_SETUP: if (expire) begin
        state_next = S_PULSE;
        tmr_load   = 1'b1;
        tmr_value  = PULSE_LD;
      end
      S_PULSE: if (expire) begin
        state_next = S_GAP;
        tmr_load   = 1'b1;
        tmr_value  = GAP_LD;
      end
      S_GAP: if (expire) begin
        tmr_load = 1'b1;
        if (nib == NIB_B_HI) begin
          state_next = S_SETTLE;
          tmr_value  = SETTLE_LD;
        end else begin
          state_next = S_SETUP;
          nib_next   = nib + 1'b1;
          tmr_value  = SETUP_LD;
        end
      end
      S_SETTLE: if (expire) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  always_comb begin
    pb_next = '0;
    y_next  = '0;
    if (state_next == S_SETUP || state_next == S_PULSE || state_next == S_GAP)
      y_next = nibble_sel(nib_next, op_a_next, op_b_next);
    if (state_next == S_PULSE)
      pb_next = 4'b0001 << nib_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      nib    <= NIB_A_LO;
      op_a   <= '0;
      op_b   <= '0;
      y      <= '0;
      pb     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      nib   <= nib_next;
      op_a  <= op_a_next;
      op_b  <= op_b_next;
      y     <= y_next;
      pb    <= pb_next;
      busy  <= (state_next != S_IDLE);
      done  <= (state == S_CAPTURE);
      if (state == S_CAPTURE)
        result <= {l2, l1, l0};
    end
  end

  assign pb1 = pb[0];
  assign pb2 = pb[1];
  assign pb3 = pb[2];
  assign pb4 = pb[3];

`ifdef CMP_DRV_CHECK_EN
  // Expected LED pattern is one-hot {A<B, A==B, A>B}; any disagreement is sticky.
  always_ff @(posedge clk) begin
    if (reset)
      mismatch <= 1'b0;
    else if (state == S_CAPTURE &&
             {op_a < op_b, op_a == op_b, op_a > op_b} != {l2, l1, l0})
      mismatch <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cmp_nibble_driver.sv
// Self-checking bench for cmp_nibble_driver: scoreboard of expected nibbles and
// results, a behavioural comparator on the strobes, and a minimum-timing instance.
module tb_cmp_nibble_driver;

  localparam int S = 2, P = 4, G = 2, T = 2;
  localparam int N_DEF = 4 * (S + P + G) + T + 1;
  localparam int N_MIN = 4 * 3 + 1 + 1;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] pb;
  } nib_t;

  typedef struct {
    logic [2:0] r;
    int         cyc;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] y;
  logic       pb1, pb2, pb3, pb4, busy, done;
  logic [2:0] result;
  logic       l0, l1, l2;

  logic       start1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic [3:0] y1;
  logic       q1, q2, q3, q4, busy1, done1;
  logic [2:0] result1;
  logic       led0_1 = 1'b1, led1_1 = 1'b0, led2_1 = 1'b0;

`ifdef CMP_DRV_CHECK_EN
  logic mismatch, mismatch1;
`endif

  int total = 0, bad = 0, cyc = 0, done_cnt = 0;
  nib_t q_nib[$];
  res_t q_res[$];

  always @(posedge clk) cyc <= cyc + 1;

  cmp_nibble_driver dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .y(y),
    .pb1(pb1), .pb2(pb2), .pb3(pb3), .pb4(pb4), .l0(l0), .l1(l1), .l2(l2),
    .busy(busy), .done(done),
`ifdef CMP_DRV_CHECK_EN
    .mismatch(mismatch),
`endif
    .result(result)
  );

  cmp_nibble_driver #(.SETUP_CYC(1), .PULSE_CYC(1), .GAP_CYC(1), .SETTLE_CYC(1)) dut_min (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .y(y1),
    .pb1(q1), .pb2(q2), .pb3(q3), .pb4(q4), .l0(led0_1), .l1(led1_1), .l2(led2_1),
    .busy(busy1), .done(done1),
`ifdef CMP_DRV_CHECK_EN
    .mismatch(mismatch1),
`endif
    .result(result1)
  );

  // Behavioural eight_bit_comp: nibble registers loaded while a strobe is high.
  logic [7:0] am = '0, bm = '0;
  logic       force_wrong = 1'b0;
  always @(posedge clk) begin
    if (pb1) am[3:0] <= y;
    if (pb2) am[7:4] <= y;
    if (pb3) bm[3:0] <= y;
    if (pb4) bm[7:4] <= y;
  end
  assign {l2, l1, l0} = force_wrong ? 3'b100 : {am < bm, am == bm, am > bm};

  // Output monitor for the default instance.
  logic [3:0] prev_pb = '0, y_hold = '0, pbv;
  int         plen = 0;
  nib_t       en;
  res_t       er;
  always @(negedge clk) begin
    pbv = {pb4, pb3, pb2, pb1};
    if (reset) begin
      prev_pb = '0;
      plen    = 0;
    end else begin
      if ($countones(pbv) > 1) begin
        total++; bad++;
        $display("FAIL pb_onehot got=%b at cyc=%0d", pbv, cyc);
      end
      if (pbv != 0 && prev_pb == 0) begin
        total++;
        if (q_nib.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected pb=%b y=%h at cyc=%0d", pbv, y, cyc);
        end else begin
          en = q_nib.pop_front();
          if (y !== en.y || pbv !== en.pb) begin
            bad++;
            $display("FAIL nibble got y=%h pb=%b exp y=%h pb=%b", y, pbv, en.y, en.pb);
          end
        end
        y_hold = y;
        plen   = 1;
      end else if (pbv != 0) begin
        plen++;
        if (y !== y_hold) begin
          total++; bad++;
          $display("FAIL y_stable got=%h exp=%h at cyc=%0d", y, y_hold, cyc);
        end
      end else if (prev_pb != 0) begin
        total++;
        if (plen != P) begin
          bad++;
          $display("FAIL pulse_len got=%0d exp=%0d", plen, P);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        total++;
        if (q_res.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected at cyc=%0d", cyc);
        end else begin
          er = q_res.pop_front();
          if (result !== er.r || busy !== 1'b0 || cyc != er.cyc) begin
            bad++;
            $display("FAIL done got result=%b busy=%b cyc=%0d exp result=%b busy=0 cyc=%0d",
                     result, busy, cyc, er.r, er.cyc);
          end
        end
      end
      prev_pb = pbv;
    end
  end

  task automatic launch(input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] exp_r, output int c0);
    @(posedge clk); #1;
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
    a = ~va; b = ~vb;
    q_nib.push_back('{va[3:0], 4'b0001});
    q_nib.push_back('{va[7:4], 4'b0010});
    q_nib.push_back('{vb[3:0], 4'b0100});
    q_nib.push_back('{vb[7:4], 4'b1000});
    q_res.push_back('{exp_r, c0 + N_DEF});
  endtask

  task automatic wait_done(input int n0, input string tag);
    int k = 0;
    while (done_cnt == n0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (done_cnt == n0) begin
      bad++;
      $display("FAIL %s_timeout got no done within %0d cycles", tag, k);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (y !== 4'h0 || {pb4, pb3, pb2, pb1} !== 4'h0 || busy !== 1'b0 ||
        done !== 1'b0 || result !== 3'b000) begin
      bad++;
      $display("FAIL reset_state got y=%h pb=%b busy=%b done=%b result=%b",
               y, {pb4, pb3, pb2, pb1}, busy, done, result);
    end
`ifdef CMP_DRV_CHECK_EN
    total++;
    if (mismatch !== 1'b0) begin
      bad++;
      $display("FAIL reset_mismatch got=%b exp=0", mismatch);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_abort_mid_pulse;
    int c0, k, n0;
    n0 = done_cnt;
    launch(8'h5A, 8'hC3, 3'b100, c0);
    k = 0;
    while (pb3 !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (pb3 !== 1'b1) begin
      bad++;
      $display("FAIL abort_reach_pb3 got=%b exp=1", pb3);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q_nib.delete();
    q_res.delete();
    total++;
    if ({pb4, pb3, pb2, pb1} !== 4'h0 || busy !== 1'b0 || y !== 4'h0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs got pb=%b busy=%b y=%h done=%b exp all 0",
               {pb4, pb3, pb2, pb1}, busy, y, done);
    end
    total++;
    if (result !== 3'b000) begin
      bad++;
      $display("FAIL abort_result got=%b exp=000", result);
    end
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (done_cnt != n0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done got dones=%0d busy=%b exp dones=%0d busy=0",
               done_cnt, busy, n0);
    end
  endtask

  task automatic test_basic;
    int c0, n0;
    n0 = done_cnt;
    launch(8'h12, 8'h34, 3'b100, c0);
    wait_done(n0, "basic");
    total++;
    if (q_nib.size() != 0 || result !== 3'b100) begin
      bad++;
      $display("FAIL basic_result got=%b left=%0d exp=100 left=0", result, q_nib.size());
    end
`ifdef CMP_DRV_CHECK_EN
    total++;
    if (mismatch !== 1'b0) begin
      bad++;
      $display("FAIL basic_mismatch got=%b exp=0", mismatch);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int c0, c1, n0;
    n0 = done_cnt;
    @(posedge clk); #1;
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    q_nib.push_back('{4'h5, 4'b0001});
    q_nib.push_back('{4'hA, 4'b0010});
    q_nib.push_back('{4'h5, 4'b0100});
    q_nib.push_back('{4'hA, 4'b1000});
    q_res.push_back('{3'b010, c0 + N_DEF});
    while (cyc < c0 + N_DEF) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || result !== 3'b010) begin
      bad++;
      $display("FAIL b2b_edge_n got busy=%b done=%b result=%b exp busy=0 done=1 result=010",
               busy, done, result);
    end
    @(posedge clk); #1;
    c1 = cyc;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept_n1 got busy=%b exp=1", busy);
    end
    start = 1'b0;
    q_nib.push_back('{4'h5, 4'b0001});
    q_nib.push_back('{4'hA, 4'b0010});
    q_nib.push_back('{4'h5, 4'b0100});
    q_nib.push_back('{4'hA, 4'b1000});
    q_res.push_back('{3'b010, c1 + N_DEF});
    wait_done(n0 + 1, "b2b_second");
  endtask

  task automatic test_min_timing;
    int c0, e;
    logic [3:0] exp_pb;
    @(posedge clk); #1;
    a1 = 8'h3C; b1 = 8'h0F; start1 = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      e = cyc - c0;
      exp_pb = (e <= 10 && (e % 3) == 1) ? (4'b0001 << ((e - 1) / 3)) : 4'b0000;
      total++;
      if ({q4, q3, q2, q1} !== exp_pb || done1 !== (e == N_MIN)) begin
        bad++;
        $display("FAIL min_timing edge=%0d got pb=%b done=%b exp pb=%b done=%b",
                 e, {q4, q3, q2, q1}, done1, exp_pb, (e == N_MIN));
      end
    end
    total++;
    if (result1 !== 3'b001 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL min_result got=%b busy=%b exp=001 busy=0", result1, busy1);
    end
  endtask

`ifdef CMP_DRV_CHECK_EN
  task automatic test_check;
    int c0, n0;
    n0 = done_cnt;
    force_wrong = 1'b1;
    launch(8'hFF, 8'h00, 3'b100, c0);
    wait_done(n0, "check_wrong");
    force_wrong = 1'b0;
    total++;
    if (mismatch !== 1'b1) begin
      bad++;
      $display("FAIL check_set got=%b exp=1", mismatch);
    end
    launch(8'h01, 8'h02, 3'b100, c0);
    wait_done(n0 + 1, "check_right");
    total++;
    if (mismatch !== 1'b1) begin
      bad++;
      $display("FAIL check_sticky got=%b exp=1", mismatch);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_abort_mid_pulse();
    test_basic();
    test_back_to_back();
    test_min_timing();
`ifdef CMP_DRV_CHECK_EN
    test_check();
`endif
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (q_res.size() != 0 || q_nib.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got res=%0d nib=%0d exp 0", q_res.size(), q_nib.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
